// File: rtl/ring_pkg.sv
// Shared constants for the ring-scanned 7-segment display mux: scan phases
// and segment codes ({g,f,e,d,c,b,a}, active high).
package ring_pkg;

  localparam logic [3:0] PH0 = 4'b1000;
  localparam logic [3:0] PH1 = 4'b0100;
  localparam logic [3:0] PH2 = 4'b0010;
  localparam logic [3:0] PH3 = 4'b0001;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

endpackage

// File: rtl/hex7seg.sv
// Combinational hex digit to 7-segment decoder, segments active high.
module hex7seg
  import ring_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_0;
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/ring_digit_mux.sv
// Double-buffered 4-digit display mux driven by an external one-hot scan ring;
// new data commits only at frame start. Macro RING_MUX_DP_EN adds decimal points.
module ring_digit_mux
  import ring_pkg::*;
#(
  parameter int BLANK_LEAD = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  PHASE,
  input  logic [15:0] DIN,
  input  logic        LOAD,
`ifdef RING_MUX_DP_EN
  input  logic [3:0]  DP_IN,
  output logic        DP,
`endif
  output logic        READY,
  output logic [6:0]  SEG,
  output logic [3:0]  AN,
  output logic        ERR
);

  logic [15:0] pend_q, pend_d, act_q, act_d;
  logic        pend_vld_q, pend_vld_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic        err_q, err_d;
  logic        phase_ok, commit, load_acc, lead_zero, blank;
  logic [3:0]  digit, zero;
  logic [6:0]  dec_seg;
`ifdef RING_MUX_DP_EN
  logic [3:0]  pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic        dp_q, dp_d;
`endif

  hex7seg u_dec (
    .hex (digit),
    .seg (dec_seg)
  );

  always_comb begin
    phase_ok   = (PHASE == PH0) || (PHASE == PH1) || (PHASE == PH2) || (PHASE == PH3);
    commit     = phase_ok && (PHASE == PH0) && pend_vld_q;
    load_acc   = LOAD && !pend_vld_q;
    pend_d     = load_acc ? DIN : pend_q;
    pend_vld_d = load_acc | (pend_vld_q & ~commit);
    // Decode from the post-commit value so digit 3 of a new frame is already new data.
    act_d      = commit ? pend_q : act_q;
    zero       = {act_d[15:12] == 4'h0, act_d[11:8] == 4'h0,
                  act_d[7:4] == 4'h0, act_d[3:0] == 4'h0};
    digit      = act_d[3:0];
    lead_zero  = 1'b0;
    if (PHASE == PH0) begin
      digit     = act_d[15:12];
      lead_zero = zero[3];
    end else if (PHASE == PH1) begin
      digit     = act_d[11:8];
      lead_zero = zero[3] & zero[2];
    end else if (PHASE == PH2) begin
      digit     = act_d[7:4];
      lead_zero = zero[3] & zero[2] & zero[1];
    end
    blank = (BLANK_LEAD != 0) && lead_zero;
    seg_d = (phase_ok && !blank) ? dec_seg : 7'h00;
    an_d  = phase_ok ? PHASE : 4'b0000;
    err_d = err_q | ~phase_ok;
  end

`ifdef RING_MUX_DP_EN
  always_comb begin
    pend_dp_d = load_acc ? DP_IN : pend_dp_q;
    act_dp_d  = commit ? pend_dp_q : act_dp_q;
    dp_d      = phase_ok && ((PHASE & act_dp_d) != 4'b0000);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_dp_q <= 4'b0000;
      act_dp_q  <= 4'b0000;
      dp_q      <= 1'b0;
    end else begin
      pend_dp_q <= pend_dp_d;
      act_dp_q  <= act_dp_d;
      dp_q      <= dp_d;
    end
  end

  assign DP = dp_q;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_q     <= 16'h0000;
      pend_vld_q <= 1'b0;
      act_q      <= 16'h0000;
      seg_q      <= 7'h00;
      an_q       <= 4'b0000;
      err_q      <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      act_q      <= act_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      err_q      <= err_d;
    end
  end

  assign READY = ~pend_vld_q;
  assign SEG   = seg_q;
  assign AN    = an_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_ring_digit_mux.sv
// Directed bench for ring_digit_mux; a second instance runs with leading-zero blanking.
module tb_ring_digit_mux;

  logic        CLK = 1'b0;
  logic        RESET, LOAD;
  logic [3:0]  PHASE;
  logic [15:0] DIN;
  logic        READY, ERR, b_ready, b_err;
  logic [6:0]  SEG, b_seg;
  logic [3:0]  AN, b_an;
`ifdef RING_MUX_DP_EN
  logic [3:0]  DP_IN;
  logic        DP, b_dp;
`endif

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  ring_digit_mux #(.BLANK_LEAD(0)) dut (
    .CLK(CLK), .RESET(RESET), .PHASE(PHASE), .DIN(DIN), .LOAD(LOAD),
`ifdef RING_MUX_DP_EN
    .DP_IN(DP_IN), .DP(DP),
`endif
    .READY(READY), .SEG(SEG), .AN(AN), .ERR(ERR)
  );

  ring_digit_mux #(.BLANK_LEAD(1)) dut_b (
    .CLK(CLK), .RESET(RESET), .PHASE(PHASE), .DIN(DIN), .LOAD(LOAD),
`ifdef RING_MUX_DP_EN
    .DP_IN(DP_IN), .DP(b_dp),
`endif
    .READY(b_ready), .SEG(b_seg), .AN(b_an), .ERR(b_err)
  );

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic [3:0] ph, input logic ld, input logic [15:0] d);
    PHASE = ph;
    LOAD  = ld;
    DIN   = d;
`ifdef RING_MUX_DP_EN
    DP_IN = 4'b0000;
`endif
    @(posedge CLK);
    #1;
    LOAD = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] e_b[4];
    e_b = '{7'h00, 7'h00, 7'h00, 7'h3F};
    RESET = 1'b1;
    cyc(4'b1000, 1'b1, 16'h1234);
    checks++;
    if (SEG !== 7'h00 || AN !== 4'b0000 || ERR !== 1'b0 || READY !== 1'b1) begin
      failures++;
      $display("FAIL reset_state seg=%h an=%b err=%b ready=%b want 00/0000/0/1", SEG, AN, ERR, READY);
    end
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(4'b1000 >> i, 1'b0, 16'h0);
      checks++;
      if (SEG !== 7'h3F || AN !== (4'b1000 >> i) || b_seg !== e_b[i]) begin
        failures++;
        $display("FAIL reset_zero_frame i=%0d seg=%h an=%b bseg=%h want 3F/%b/%h",
                 i, SEG, AN, b_seg, 4'b1000 >> i, e_b[i]);
      end
    end
  endtask

  task automatic test_load_commit();
    logic [6:0] e[4];
    e = '{7'h06, 7'h5B, 7'h4F, 7'h66};
    cyc(4'b0001, 1'b1, 16'h1234);
    checks++;
    if (READY !== 1'b0) begin
      failures++;
      $display("FAIL load_ready_low ready=%b want 0", READY);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(4'b1000 >> i, 1'b0, 16'h0);
      checks++;
      if (SEG !== e[i] || AN !== (4'b1000 >> i) || READY !== 1'b1) begin
        failures++;
        $display("FAIL commit_1234 i=%0d seg=%h an=%b ready=%b want %h/%b/1",
                 i, SEG, AN, READY, e[i], 4'b1000 >> i);
      end
    end
  endtask

  task automatic test_ignore_load();
    logic [6:0] e[4];
    e = '{7'h06, 7'h5B, 7'h4F, 7'h66};
    cyc(4'b1000, 1'b0, 16'h0);
    cyc(4'b0100, 1'b1, 16'h1234);
    cyc(4'b0010, 1'b1, 16'hFFFF);
    checks++;
    if (READY !== 1'b0 || SEG !== 7'h4F) begin
      failures++;
      $display("FAIL ignore_busy ready=%b seg=%h want 0/4F", READY, SEG);
    end
    cyc(4'b0001, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(4'b1000 >> i, 1'b0, 16'h0);
      checks++;
      if (SEG !== e[i] || READY !== 1'b1) begin
        failures++;
        $display("FAIL ignore_frame i=%0d seg=%h ready=%b want %h/1", i, SEG, READY, e[i]);
      end
    end
  endtask

  task automatic test_mid_frame_load();
    logic [6:0] cur[4];
    logic [6:0] e[4];
    cur = '{7'h06, 7'h5B, 7'h4F, 7'h66};
    e   = '{7'h77, 7'h7C, 7'h39, 7'h5E};
    for (int i = 0; i < 4; i++) begin
      cyc(4'b1000 >> i, (i == 1), 16'hABCD);
      checks++;
      if (SEG !== cur[i]) begin
        failures++;
        $display("FAIL no_tear i=%0d seg=%h want %h", i, SEG, cur[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(4'b1000 >> i, 1'b0, 16'h0);
      checks++;
      if (SEG !== e[i] || AN !== (4'b1000 >> i)) begin
        failures++;
        $display("FAIL abcd_frame i=%0d seg=%h an=%b want %h/%b", i, SEG, AN, e[i], 4'b1000 >> i);
      end
    end
  endtask

  task automatic test_load_at_frame_start();
    logic [6:0] cur[4];
    logic [6:0] e[4];
    cur = '{7'h77, 7'h7C, 7'h39, 7'h5E};
    e   = '{7'h7F, 7'h3F, 7'h3F, 7'h7F};
    for (int i = 0; i < 4; i++) begin
      cyc(4'b1000 >> i, (i == 0), 16'h8008);
      checks++;
      if (SEG !== cur[i] || READY !== 1'b0) begin
        failures++;
        $display("FAIL ph0_load_nocommit i=%0d seg=%h ready=%b want %h/0", i, SEG, READY, cur[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(4'b1000 >> i, 1'b0, 16'h0);
      checks++;
      if (SEG !== e[i] || b_seg !== e[i]) begin
        failures++;
        $display("FAIL frame_8008 i=%0d seg=%h bseg=%h want %h", i, SEG, b_seg, e[i]);
      end
    end
  endtask

  task automatic test_blank_lead();
    logic [6:0] e[4];
    logic [6:0] e_b[4];
    e   = '{7'h3F, 7'h3F, 7'h07, 7'h3F};
    e_b = '{7'h00, 7'h00, 7'h07, 7'h3F};
    cyc(4'b0001, 1'b1, 16'h0070);
    for (int i = 0; i < 4; i++) begin
      cyc(4'b1000 >> i, 1'b0, 16'h0);
      checks++;
      if (SEG !== e[i] || b_seg !== e_b[i] || b_an !== (4'b1000 >> i)) begin
        failures++;
        $display("FAIL blank_0070 i=%0d seg=%h bseg=%h ban=%b want %h/%h/%b",
                 i, SEG, b_seg, b_an, e[i], e_b[i], 4'b1000 >> i);
      end
    end
    e_b = '{7'h00, 7'h00, 7'h00, 7'h3F};
    cyc(4'b0001, 1'b1, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      cyc(4'b1000 >> i, 1'b0, 16'h0);
      checks++;
      if (b_seg !== e_b[i] || SEG !== 7'h3F) begin
        failures++;
        $display("FAIL blank_0000 i=%0d bseg=%h seg=%h want %h/3F", i, b_seg, SEG, e_b[i]);
      end
    end
  endtask

  task automatic test_illegal_phase();
    cyc(4'b0001, 1'b1, 16'h1111);
    cyc(4'b1100, 1'b0, 16'h0);
    checks++;
    if (AN !== 4'b0000 || SEG !== 7'h00 || ERR !== 1'b1 || READY !== 1'b0) begin
      failures++;
      $display("FAIL illegal_phase an=%b seg=%h err=%b ready=%b want 0000/00/1/0", AN, SEG, ERR, READY);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(4'b1000 >> i, 1'b0, 16'h0);
      checks++;
      if (SEG !== 7'h06 || ERR !== 1'b1 || b_err !== 1'b1 || READY !== 1'b1) begin
        failures++;
        $display("FAIL err_sticky i=%0d seg=%h err=%b berr=%b ready=%b want 06/1/1/1",
                 i, SEG, ERR, b_err, READY);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    cyc(4'b1000, 1'b0, 16'h0);
    cyc(4'b0100, 1'b1, 16'h9999);
    RESET = 1'b1;
    cyc(4'b0010, 1'b0, 16'h0);
    checks++;
    if (SEG !== 7'h00 || AN !== 4'b0000 || ERR !== 1'b0 || READY !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid seg=%h an=%b err=%b ready=%b want 00/0000/0/1", SEG, AN, ERR, READY);
    end
    RESET = 1'b0;
    cyc(4'b0001, 1'b0, 16'h0);
    checks++;
    if (SEG !== 7'h3F || AN !== 4'b0001 || b_seg !== 7'h3F) begin
      failures++;
      $display("FAIL resume_d0 seg=%h an=%b bseg=%h want 3F/0001/3F", SEG, AN, b_seg);
    end
    cyc(4'b1000, 1'b0, 16'h0);
    checks++;
    if (SEG !== 7'h3F || b_seg !== 7'h00 || READY !== 1'b1) begin
      failures++;
      $display("FAIL resume_discard seg=%h bseg=%h ready=%b want 3F/00/1", SEG, b_seg, READY);
    end
  endtask

  initial begin
    RESET = 1'b1;
    LOAD  = 1'b0;
    PHASE = 4'b0000;
    DIN   = 16'h0;
`ifdef RING_MUX_DP_EN
    DP_IN = 4'b0000;
`endif
    #1;
    test_reset();
    test_load_commit();
    test_ignore_load();
    test_mid_frame_load();
    test_load_at_frame_start();
    test_blank_lead();
    test_illegal_phase();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
